arb_mux2_1: RTL and testbench
=============================

// Module: arb_mux2_1
// PURPOSE
//  Merges two WIDTH-bit valid/ready input streams (in1, in2) into one registered output stream.
//  Arbitration is round-robin with a bounded burst length.
//  out_sel tags each beat with its source, using the same encoding as the sel input of the
//  1-to-2 demux: 0=in1, 1=in2. A downstream demux can therefore route responses back.
//  Sits upstream of shared datapath resources that are fed by two producers.
// PARAMETERS
//  WIDTH       8  data width of in1/in2/out
//  MAX_BURST   4  max consecutive beats granted to one side while the other waits; legal 1..255
//  PRIO_RESET  0  side holding priority after reset (0=in1, 1=in2)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  enable     in   1      1=accept inputs; 0=stop accepting (output still drains)
//  in1_data   in   WIDTH  source 1 data
//  in1_valid  in   1      source 1 beat available
//  in1_ready  out  1      source 1 beat accepted this cycle when in1_valid=1
//  in2_data   in   WIDTH  source 2 data
//  in2_valid  in   1      source 2 beat available
//  in2_ready  out  1      source 2 beat accepted this cycle when in2_valid=1
//  out_data   out  WIDTH  merged data (registered)
//  out_valid  out  1      out_data/out_sel valid
//  out_ready  in   1      sink accepts the beat when out_valid=1
//  out_sel    out  1      source of the current out beat (0=in1, 1=in2)
//  busy       out  1      (state!=IDLE) | out_valid
// BEHAVIOUR
//  Reset (rst=1 at edge): out_valid=0, out_data=0, out_sel=0, state=IDLE, cnt=0, prio=PRIO_RESET.
//    Any beat held in the output register is discarded.
//  Upstream rule: inX_valid/inX_data are held until accepted. Sink rule: standard valid/ready.
//  Output register: one entry. load_ok = !out_valid | out_ready.
//  inX_ready = enable & load_ok & (grant==X). This is combinational from out_ready.
//    Only one ready is high per cycle.
//  Latency: a beat accepted at edge N is presented on out at N+1.
//    Full rate is 1 beat/cycle when out_ready=1 is held.
//  Simultaneous drain and load: the load wins and out_valid stays 1.
//    Drain only: out_valid goes to 0; out_data/out_sel hold their last value.
//  While out_valid & !out_ready, out_data and out_sel are stable.
//  FSM states: IDLE, G1, G2. Burst counter cnt saturates at MAX_BURST.
//  Combinational grant:
//    IDLE: grant = the valid side. If both are valid, grant = prio. If neither, grant = none.
//    G1: grant=1 if in1_valid & (cnt<MAX_BURST | !in2_valid).
//        Else grant=2 if in2_valid. Else none. G2 is symmetric.
//  On an accepted beat from side X:
//    - if state==GX: cnt<=cnt+1, saturating.
//    - else: state<=GX and cnt<=1.
//    - in both cases prio <= the other side.
//  No accept and neither input valid: state<=IDLE, cnt<=0.
//  No accept because of backpressure (load_ok=0): state and cnt hold.
//  enable=0: no accepts; state<=IDLE, cnt<=0; prio holds; the output register drains normally.
//  MAX_BURST=1: strict alternation while both inputs are valid.
//  A starved side waits at most MAX_BURST accepted beats.
// STRUCTURE
//  package common:
//    - typedef enum logic [1:0] {ARB_IDLE, ARB_G1, ARB_G2} arb_state_e
//    - localparam SEL_IN1=1'b0, SEL_IN2=1'b1 (shared with the demux sel encoding)
//  Sub-module arb_grant2: purely combinational grant computation
//    (state, cnt, prio, valids -> grant).
//  The top level holds the FSM/counter/prio registers, the output register and the ready logic.
// TESTING
//  1. Reset: rst=1 for 2 cycles with both valids high.
//     -> out_valid=0, out_data=0, out_sel=0, busy=0, both readies 0 during reset.
//  2. Stream in1 only, data 0x11,0x12,0x13,0x14, out_ready=1.
//     -> out 0x11..0x14 on consecutive cycles, each 1 cycle after accept, out_sel=0, no bubbles.
//  3. Both valid continuously, in1=0xA0+n, in2=0xB0+n, MAX_BURST=4, PRIO_RESET=0.
//     -> out_sel = 0,0,0,0,1,1,1,1,0,...; per-source order preserved.
//  4. Hold out_ready=0 for 3 cycles while out_valid=1 (data 0x5A).
//     -> out_data=0x5A stable, in1_ready=in2_ready=0; on release there is no loss and no duplicate.
//  5. enable=0 for 2 cycles in mid-burst (cnt=2).
//     -> readies drop the same cycle, the pending beat drains, state IDLE.
//     -> after re-enable, a fresh burst of 4.
//  6. rst=1 for 1 cycle mid-burst with out_valid=1.
//     -> out_valid=0 next cycle; the next grant with both valid goes to PRIO_RESET.

Source files
------------

// File: rtl/arb_mux2_1_pkg.sv
// arb_mux2_1_pkg: shared types and encodings for the two-input round-robin merge
package arb_mux2_1_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_G1, ARB_G2} arb_state_e;
    typedef enum logic [1:0] {GNT_NONE, GNT_IN1, GNT_IN2} grant_e;
    localparam logic SEL_IN1 = 1'b0;
    localparam logic SEL_IN2 = 1'b1;
    localparam int CNT_W = 8;
endpackage

// File: rtl/arb_mux2_1_if.sv
// arb_mux2_1_if: two valid/ready producer streams and one tagged consumer stream
interface arb_mux2_1_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] in1_data;
    logic             in1_valid;
    logic             in1_ready;
    logic [WIDTH-1:0] in2_data;
    logic             in2_valid;
    logic             in2_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sel;
    modport slave (
        input  in1_data, in1_valid, in2_data, in2_valid, out_ready,
        output in1_ready, in2_ready, out_data, out_valid, out_sel
    );
    modport master (
        output in1_data, in1_valid, in2_data, in2_valid, out_ready,
        input  in1_ready, in2_ready, out_data, out_valid, out_sel
    );
endinterface

// File: rtl/arb_mux2_1_grant2.sv
// arb_grant2: combinational round-robin grant with bounded burst length
module arb_grant2
    import arb_mux2_1_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  arb_state_e       state,
    input  logic [CNT_W-1:0] cnt,
    input  logic             prio,
    input  logic             v1,
    input  logic             v2,
    output grant_e           grant
);
    localparam logic [CNT_W-1:0] MB = CNT_W'(MAX_BURST);
    logic stay1, stay2;
    assign stay1 = v1 && (cnt < MB || !v2);
    assign stay2 = v2 && (cnt < MB || !v1);
    // IDLE breaks ties with prio; a busy side keeps the grant until its burst is used up
    assign grant = (state == ARB_G1) ? (stay1 ? GNT_IN1 : v2 ? GNT_IN2 : GNT_NONE)
                 : (state == ARB_G2) ? (stay2 ? GNT_IN2 : v1 ? GNT_IN1 : GNT_NONE)
                 : (v1 && v2) ? ((prio == SEL_IN2) ? GNT_IN2 : GNT_IN1)
                 : v1 ? GNT_IN1 : v2 ? GNT_IN2 : GNT_NONE;
endmodule

// File: rtl/arb_mux2_1.sv
// arb_mux2_1: round-robin merge of two streams into one registered, source-tagged stream
module arb_mux2_1
    import arb_mux2_1_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_BURST  = 4,
    parameter int PRIO_RESET = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    arb_mux2_1_if.slave   bus,
    output logic          busy
);
    arb_state_e       state;
    arb_state_e       acc_state;
    logic [CNT_W-1:0] cnt;
    logic             prio;
    grant_e           grant;
    logic             load_ok, acc1, acc2;

    arb_grant2 #(.MAX_BURST(MAX_BURST)) u_grant (
        .state(state),
        .cnt  (cnt),
        .prio (prio),
        .v1   (bus.in1_valid),
        .v2   (bus.in2_valid),
        .grant(grant)
    );

    assign load_ok       = !bus.out_valid || bus.out_ready;
    assign bus.in1_ready = !rst && enable && load_ok && grant == GNT_IN1;
    assign bus.in2_ready = !rst && enable && load_ok && grant == GNT_IN2;
    assign acc1          = bus.in1_ready && bus.in1_valid;
    assign acc2          = bus.in2_ready && bus.in2_valid;
    assign acc_state     = acc2 ? ARB_G2 : ARB_G1;
    assign busy          = state != ARB_IDLE || bus.out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ARB_IDLE;
            cnt           <= '0;
            prio          <= 1'(PRIO_RESET);
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= SEL_IN1;
        end else begin
            if (acc1 || acc2) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= acc2 ? bus.in2_data : bus.in1_data;
                bus.out_sel   <= acc2 ? SEL_IN2 : SEL_IN1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (acc1 || acc2) begin
                state <= acc_state;
                cnt   <= (state != acc_state) ? CNT_W'(1)
                       : (cnt == CNT_W'(MAX_BURST)) ? cnt : cnt + 1'b1;
                prio  <= acc2 ? SEL_IN1 : SEL_IN2;
            end else if (!enable || (!bus.in1_valid && !bus.in2_valid)) begin
                state <= ARB_IDLE;
                cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_arb_mux2_1.sv
// tb_arb_mux2_1: scoreboard bench with a run-length reference model of the arbiter
module tb_arb_mux2_1;
    localparam int WIDTH      = 8;
    localparam int MAX_BURST  = 4;
    localparam int PRIO_RESET = 0;

    logic clk, rst, enable, busy;
    arb_mux2_1_if #(.WIDTH(WIDTH)) bus ();

    arb_mux2_1 #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST), .PRIO_RESET(PRIO_RESET)) dut (
        .clk(clk), .rst(rst), .enable(enable), .bus(bus), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, passes = 0;
    logic [WIDTH-1:0] q1[$], q2[$];
    logic [WIDTH:0]   sb[$];
    bit               seen[$];
    bit               rec = 1'b0;
    bit               hold[2];
    int               m_owner, m_run;
    bit               m_prio, m_ov;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Who should win: lone requester wins; on contention the current owner keeps
    // the grant until it has used MAX_BURST beats, a fresh start goes to prio.
    function automatic int pick(input bit v1, input bit v2);
        if (!v1 && !v2) return -1;
        if (!(v1 && v2)) return v2 ? 1 : 0;
        if (m_owner < 0) return int'(m_prio);
        return (m_run < MAX_BURST) ? m_owner : 1 - m_owner;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_run   = 0;
        m_prio  = 1'(PRIO_RESET);
        m_ov    = 1'b0;
        sb.delete();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; enable = 1'b1; bus.out_ready = 1'b1;
        bus.in1_valid = 1'b1; bus.in2_valid = 1'b1;
        bus.in1_data = q1.size() > 0 ? q1[0] : 8'hEE;
        bus.in2_data = q2.size() > 0 ? q2[0] : 8'hEE;
        #1;
        chk("rst_in1_ready", bus.in1_ready, 0);
        chk("rst_in2_ready", bus.in2_ready, 0);
        repeat (n) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_sel", bus.out_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready_hold", {bus.in1_ready, bus.in2_ready}, 0);
        rst = 1'b0;
        model_reset();
        hold[0] = q1.size() > 0;
        hold[1] = q2.size() > 0;
    endtask

    // One clock: drive, check readies/outputs against the model, clock, update model.
    task automatic step(input bit en, input bit a1, input bit a2, input bit ordy);
        bit v1, v2, acc;
        int g;
        enable = en; bus.out_ready = ordy;
        v1 = q1.size() > 0 && (hold[0] || a1);
        v2 = q2.size() > 0 && (hold[1] || a2);
        bus.in1_valid = v1; bus.in1_data = v1 ? q1[0] : '0;
        bus.in2_valid = v2; bus.in2_data = v2 ? q2[0] : '0;
        #1;
        g   = pick(v1, v2);
        acc = en && (!m_ov || ordy) && g >= 0;
        chk("in1_ready", bus.in1_ready, acc && g == 0);
        chk("in2_ready", bus.in2_ready, acc && g == 1);
        chk("out_valid", bus.out_valid, m_ov);
        chk("busy", busy, m_owner >= 0 || m_ov);
        if (m_ov && sb.size() > 0) chk("out_stable", {bus.out_sel, bus.out_data}, sb[0]);
        @(posedge clk);
        #1;
        if (acc) begin
            sb.push_back({g == 1, g == 1 ? q2.pop_front() : q1.pop_front()});
            if (m_owner == g) m_run++;
            else begin m_owner = g; m_run = 1; end
            m_prio = (g == 0);
        end else if (!en || (!v1 && !v2)) begin
            m_owner = -1; m_run = 0;
        end
        m_ov    = acc ? 1'b1 : (ordy ? 1'b0 : m_ov);
        hold[0] = v1 && !(acc && g == 0);
        hold[1] = v2 && !(acc && g == 1);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL out_beat: got %0h expected no beat at %0t", {bus.out_sel, bus.out_data}, $time);
            end else chk("out_beat", {bus.out_sel, bus.out_data}, sb.pop_front());
            if (rec) seen.push_back(bus.out_sel);
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b0; bus.out_ready = 1'b0;
        bus.in1_valid = 1'b0; bus.in2_valid = 1'b0; bus.in1_data = '0; bus.in2_data = '0;
        hold[0] = 1'b0; hold[1] = 1'b0;
        model_reset();
        @(posedge clk); #1;
        do_reset(2);
        for (int i = 0; i < 4; i++) q1.push_back(8'h11 + 8'(i));
        repeat (6) step(1, 1, 0, 1);
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            q1.push_back(8'hA0 + 8'(i));
            q2.push_back(8'hB0 + 8'(i));
        end
        rec = 1'b1;
        repeat (18) step(1, 1, 1, 1);
        rec = 1'b0;
        chk("burst_count", seen.size(), 16);
        for (int i = 0; i < 16 && i < seen.size(); i++) chk("burst_sel", seen[i], (i / 4) % 2);
        q1.push_back(8'h5A);
        step(1, 1, 0, 0);
        q2.push_back(8'h77);
        repeat (3) step(1, 0, 1, 0);
        repeat (3) step(1, 0, 1, 1);
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            q1.push_back(8'hC0 + 8'(i));
            q2.push_back(8'hD0 + 8'(i));
        end
        repeat (2) step(1, 1, 1, 1);
        repeat (2) step(0, 1, 1, 1);
        repeat (6) step(1, 1, 1, 1);
        do_reset(1);
        repeat (14) step(1, 1, 1, 1);
        for (int i = 0; i < 1500; i++) begin
            if (q1.size() < 2) q1.push_back(8'($urandom));
            if (q2.size() < 2) q2.push_back(8'($urandom));
            step($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), $urandom_range(0, 9) < 7);
        end
        q1.delete(); q2.delete();
        hold[0] = 1'b0; hold[1] = 1'b0;
        repeat (4) step(1, 0, 0, 1);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
